// File: rtl/perf_counter_master.sv
// Command-driven master for a sectioned performance-counter slave.
// It issues GO/STOP/CLEAR writes and takes torn-read-safe 64-bit time snapshots with bounded retry.
module perf_counter_master #(
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_section,
  output logic [3:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic        avm_begintransfer,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_time,
  output logic [31:0] res_events,
  output logic [1:0]  res_section,
  output logic        res_error,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RD_HI, S_RD_LO, S_RD_HI2, S_RD_EV, S_CHECK
  } state_t;

  localparam logic [1:0] OP_GO    = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_SNAP  = 2'd3;
  localparam logic [3:0] MAX_RETRY_W = 4'(MAX_RETRY);

  state_t      r_state, w_next;
  logic [1:0]  r_op, r_sec;
  logic [3:0]  r_retry;
  logic [31:0] r_hi1, r_lo, r_hi2;
  logic        r_res_valid, r_res_error;
  logic [63:0] r_res_time;
  logic [31:0] r_res_events;
  logic [1:0]  r_res_section;
  logic        w_accept, w_done, w_retry_inc;
  logic [3:0]  w_base;

  // Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready;
  // a result transfers on a rising edge where res_valid & res_ready.
  assign cmd_ready = (r_state == S_IDLE) && !r_res_valid;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_base    = {r_sec, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_address   = 4'd0;
    avm_writedata = 32'd0;
    w_done        = 1'b0;
    w_retry_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = (cmd_op == OP_SNAP) ? S_RD_HI : S_WRITE;
      end
      S_WRITE: begin
        avm_write = 1'b1;
        case (r_op)
          OP_GO:    avm_address = w_base + 4'd1;
          OP_STOP:  avm_address = w_base;
          OP_CLEAR: avm_writedata = 32'd1;
          default:  avm_address = 4'd0;
        endcase
        w_next = S_IDLE;
      end
      S_RD_HI:  begin avm_read = 1'b1; avm_address = w_base + 4'd1; w_next = S_RD_LO;  end
      S_RD_LO:  begin avm_read = 1'b1; avm_address = w_base;        w_next = S_RD_HI2; end
      S_RD_HI2: begin avm_read = 1'b1; avm_address = w_base + 4'd1; w_next = S_RD_EV;  end
      S_RD_EV:  begin avm_read = 1'b1; avm_address = w_base + 4'd2; w_next = S_CHECK;  end
      S_CHECK: begin
        // A changed high word means lo may belong to either epoch; re-read unless out of retries.
        if ((r_hi1 == r_hi2) || (r_retry == MAX_RETRY_W)) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_retry_inc = 1'b1;
          w_next      = S_RD_HI;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign avm_begintransfer = avm_read | avm_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op          <= 2'd0;
      r_sec         <= 2'd0;
      r_retry       <= 4'd0;
      r_hi1         <= 32'd0;
      r_lo          <= 32'd0;
      r_hi2         <= 32'd0;
      r_res_valid   <= 1'b0;
      r_res_error   <= 1'b0;
      r_res_time    <= 64'd0;
      r_res_events  <= 32'd0;
      r_res_section <= 2'd0;
    end else begin
      if (w_accept) begin
        r_op  <= cmd_op;
        r_sec <= cmd_section;
        if (cmd_op == OP_SNAP) r_retry <= 4'd0;
      end
      // Slave data lags the address by one cycle.
      if (r_state == S_RD_LO)  r_hi1 <= avm_readdata;
      if (r_state == S_RD_HI2) r_lo  <= avm_readdata;
      if (r_state == S_RD_EV)  r_hi2 <= avm_readdata;
      if (w_retry_inc) r_retry <= r_retry + 4'd1;
      if (w_done) begin
        r_res_valid   <= 1'b1;
        r_res_time    <= {r_hi2, r_lo};
        r_res_events  <= avm_readdata;
        r_res_section <= r_sec;
        r_res_error   <= (r_hi1 != r_hi2);
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign res_valid   = r_res_valid;
  assign res_time    = r_res_time;
  assign res_events  = r_res_events;
  assign res_section = r_res_section;
  assign res_error   = r_res_error;
  assign o_dbg_state = r_state;

endmodule

// File: doc/perf_counter_master.md
PERF_COUNTER_MASTER -- requirements
Module: perf_counter_master

Interface
REQ-001 Parameter MAX_RETRY, default 3, is the maximum number of snapshot re-reads after a high-word mismatch before an error is flagged (range 0..15).
REQ-002 clk  input  1  single clock; all logic is rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge.
REQ-006 cmd_op  input  2  command: 0=GO, 1=STOP, 2=CLEAR_ALL, 3=SNAPSHOT.
REQ-007 cmd_section  input  2  counter section 0..3.
REQ-008 avm_address  output  4  word address toward the counter slave.
REQ-009 avm_read  output  1  read strobe.
REQ-010 avm_write  output  1  write strobe.
REQ-011 avm_begintransfer  output  1  asserted on every cycle that avm_read or avm_write is asserted.
REQ-012 avm_writedata  output  32  write data.
REQ-013 avm_readdata  input  32  slave read data, with a fixed latency of 1 cycle and no waitrequest.
REQ-014 res_valid  output  1  snapshot result available.
REQ-015 res_ready  input  1  result consumed when res_valid & res_ready.
REQ-016 res_time  output  64  snapshot time count {hi, lo}.
REQ-017 res_events  output  32  snapshot event count.
REQ-018 res_section  output  2  section of the result.
REQ-019 res_error  output  1  the result exceeded MAX_RETRY; res_time holds the last read.

Function
REQ-020 Section base address is 4*cmd_section: +0 = time lo / stop, +1 = time hi / go, +2 = events.
REQ-021 State machine states are IDLE, WRITE, RD_HI, RD_LO, RD_HI2, RD_EV, CHECK.
REQ-022 cmd_ready shall be 1 only in IDLE with res_valid=0, and shall be combinational from state and res_valid.
REQ-023 Command fields shall be latched on acceptance at cycle T.
REQ-024 GO, STOP and CLEAR_ALL shall move the FSM to WRITE at T+1.
REQ-025 In WRITE, avm_write=1 and avm_begintransfer=1 for exactly one cycle, then the FSM returns to IDLE (cmd_ready=1 again at T+2).
REQ-026 GO shall drive address base+1 with data 0.
REQ-027 STOP shall drive address base+0 with data 0.
REQ-028 CLEAR_ALL shall drive address 0 with data 1, regardless of cmd_section.
REQ-029 SNAPSHOT shall move the FSM to RD_HI at T+1, then RD_LO, RD_HI2, RD_EV and CHECK on consecutive cycles.
REQ-030 avm_read and avm_begintransfer shall be 1 in the four RD_* states and 0 elsewhere.
REQ-031 Read addresses shall be: RD_HI base+1, RD_LO base+0, RD_HI2 base+1, RD_EV base+2.
REQ-032 Read data is captured one cycle after the address is presented: hi1 in RD_LO, lo in RD_HI2, hi2 in RD_EV, events in CHECK.
REQ-033 In CHECK, if hi1==hi2 or the retry count equals MAX_RETRY, the block shall load res_time={hi2,lo}, res_events, res_section and res_error=(hi1!=hi2), set res_valid=1 from the next cycle, and go to IDLE.
REQ-034 In CHECK, otherwise, the retry count shall increment and the FSM return to RD_HI.
REQ-035 The retry count shall be cleared on each SNAPSHOT acceptance.
REQ-036 A snapshot without a retry shall present res_valid at T+6.
REQ-037 Result registers shall hold stable while res_valid=1 and res_ready=0.
REQ-038 res_valid shall clear on the cycle after the handshake.
REQ-039 avm_read and avm_write shall never be asserted together.
REQ-040 avm_address and avm_writedata shall be 0 when no strobe is active.
REQ-041 cmd_valid is ignored when cmd_ready=0; no command is queued.

Reset
REQ-042 While reset=1, the FSM shall go to IDLE at the next edge, discarding any in-flight command or snapshot.
REQ-043 While reset=1, all outputs other than cmd_ready shall be 0 (res_*, avm_*), and the retry count shall be 0.
REQ-044 cmd_ready shall be 1 on the first cycle after reset deasserts.
REQ-045 A reset asserted mid-write shall terminate the strobe on the next edge; no partial result shall ever appear.

Verification
REQ-046 GO on section 2 -> one cycle with avm_write=1, address=9, data=0; cmd_ready low for exactly 1 cycle.
REQ-047 CLEAR_ALL with section=3 -> address=0, data=1, single write.
REQ-048 SNAPSHOT section 1, slave model returning hi=0x5, lo=0x1234, events=7 -> res_valid at T+6 with res_time=0x0000000500001234, res_events=7, res_section=1, res_error=0.
REQ-049 SNAPSHOT with hi changing 0x5->0x6 between the reads, then stable -> exactly one retry, res_time high word=0x6, res_error=0.
REQ-050 Hi differing on every pass with MAX_RETRY=3 -> 4 read passes, res_error=1; a new command is blocked until res_ready.
REQ-051 Reset asserted during RD_LO -> strobes 0 next cycle, res_valid never rises, cmd_ready=1 after reset.
